// File: rtl/fifoenrc.sv
// Two-phase synchronous FWFT FIFO: next state is captured on ph2 and published on ph1.
// Outputs are decoded from the published (slave) state only.
module fifoenrc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AFULL = 3
) (
    input  logic                   ph1,
    input  logic                   ph2,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushd,
    input  logic                   pop,
    output logic [WIDTH-1:0]       popd,
    output logic                   full,
    output logic                   empty,
    output logic                   afull,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // published state (ph1)
    logic [AW-1:0]    rd_s, wr_s;
    logic [CW-1:0]    cnt_s;
    logic             ovf_s, unf_s;

    // captured state (ph2)
    logic [AW-1:0]    rd_m, wr_m, wa_m;
    logic [CW-1:0]    cnt_m;
    logic             ovf_m, unf_m, we_m;
    logic [WIDTH-1:0] wd_m;

    // next state
    logic [AW-1:0]    rd_n, wr_n, wa_n;
    logic [CW-1:0]    cnt_n;
    logic             ovf_n, unf_n, we_n;
    logic [WIDTH-1:0] wd_n;

    logic             do_push, do_pop;

    assign empty     = (cnt_s == '0);
    assign full      = (cnt_s == CW'(DEPTH));
    assign afull     = (cnt_s >= CW'(AFULL));
    assign count     = cnt_s;
    assign overflow  = ovf_s;
    assign underflow = unf_s;
    assign popd      = empty ? '0 : mem[rd_s];

    // a pop frees the head slot, so a full FIFO still accepts push+pop
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_comb begin
        rd_n  = rd_s;
        wr_n  = wr_s;
        cnt_n = cnt_s;
        ovf_n = ovf_s;
        unf_n = unf_s;
        we_n  = 1'b0;
        wa_n  = wr_s;
        wd_n  = pushd;
        if (clear) begin
            rd_n  = '0;
            wr_n  = '0;
            cnt_n = '0;
        end else begin
            if (do_push) begin
                we_n = 1'b1;
                wr_n = wr_s + AW'(1);
            end
            if (do_pop) begin
                rd_n = rd_s + AW'(1);
            end
            if (push && !do_push) begin
                ovf_n = 1'b1;
            end
            if (pop && !do_pop) begin
                unf_n = 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_n = cnt_s + CW'(1);
                2'b01:   cnt_n = cnt_s - CW'(1);
                default: cnt_n = cnt_s;
            endcase
        end
    end

    always_ff @(posedge ph2) begin
        if (reset) begin
            rd_m  <= '0;
            wr_m  <= '0;
            cnt_m <= '0;
            ovf_m <= 1'b0;
            unf_m <= 1'b0;
            we_m  <= 1'b0;
        end else begin
            rd_m  <= rd_n;
            wr_m  <= wr_n;
            cnt_m <= cnt_n;
            ovf_m <= ovf_n;
            unf_m <= unf_n;
            we_m  <= we_n;
        end
        wa_m <= wa_n;
        wd_m <= wd_n;
    end

    // storage is written in the publish phase so popd never changes between ph2 and ph1
    always_ff @(posedge ph1) begin
        rd_s  <= rd_m;
        wr_s  <= wr_m;
        cnt_s <= cnt_m;
        ovf_s <= ovf_m;
        unf_s <= unf_m;
        if (we_m) begin
            mem[wa_m] <= wd_m;
        end
    end

endmodule

// File: tb/tb_fifoenrc.sv
// Randomized and directed bench for fifoenrc against a queue-based reference model.
module tb_fifoenrc;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = 3;

    logic             ph1, ph2, reset, clear, push, pop;
    logic [WIDTH-1:0] pushd, popd;
    logic             full, empty, afull, overflow, underflow;
    logic [2:0]       count;

    fifoenrc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset), .clear(clear),
        .push(push), .pushd(pushd), .pop(pop), .popd(popd),
        .full(full), .empty(empty), .afull(afull), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] q[$];
    bit  m_ovf = 1'b0;
    bit  m_unf = 1'b0;
    bit  m_valid = 1'b0;

    // two nonoverlapping phases, 10 time units per cycle
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        #2;
        forever begin
            ph1 = 1'b1; #4;
            ph1 = 1'b0; #1;
            ph2 = 1'b1; #4;
            ph2 = 1'b0; #1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // reference model: queue semantics applied at the capture phase
    always @(posedge ph2) begin
        bit p, o;
        if (reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (clear) begin
            q.delete();
        end else begin
            p = push;
            o = pop;
            if (o && q.size() == 0) begin
                m_unf = 1'b1;
                o = 1'b0;
            end
            if (p && q.size() == DEPTH && !o) begin
                m_ovf = 1'b1;
                p = 1'b0;
            end
            if (o) void'(q.pop_front());
            if (p) q.push_back(pushd);
        end
    end

    always @(posedge ph1) begin
        #2;
        if (m_valid) begin
            chk("m_popd",      popd,               (q.size() != 0) ? q[0] : 32'h0);
            chk("m_count",     32'(count),         32'(q.size()));
            chk("m_empty",     32'(empty),         32'(q.size() == 0));
            chk("m_full",      32'(full),          32'(q.size() == DEPTH));
            chk("m_afull",     32'(afull),         32'(q.size() >= AFULL));
            chk("m_overflow",  32'(overflow),      32'(m_ovf));
            chk("m_underflow", 32'(underflow),     32'(m_unf));
        end
    end

    // apply one cycle of inputs and return once its result is visible
    task automatic tick(input bit r, input bit c, input bit p, input logic [WIDTH-1:0] d, input bit o);
        reset = r;
        clear = c;
        push  = p;
        pushd = d;
        pop   = o;
        @(posedge ph1);
        #3;
    endtask

    initial begin
        logic [WIDTH-1:0] seq [4];
        reset = 1'b1; clear = 1'b0; push = 1'b1; pushd = 32'hDEAD; pop = 1'b0;

        // reset with push asserted
        tick(1, 0, 1, 32'hDEAD, 0);
        tick(1, 0, 1, 32'hBEEF, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_popd",  popd, 32'h0);

        // fill
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33; seq[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, seq[i], 0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(afull), 32'(i >= 2));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_popd", popd, 32'h11);

        // push+pop while full
        tick(0, 0, 1, 32'h55, 1);
        chk("fpp_popd",  popd, 32'h22);
        chk("fpp_count", 32'(count), 32'd4);
        chk("fpp_ovf",   32'(overflow), 32'd0);
        seq[0] = 32'h33; seq[1] = 32'h44; seq[2] = 32'h55; seq[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 32'h0, 1);
            chk("drain_popd", popd, seq[i]);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // push+pop while empty
        tick(0, 0, 1, 32'hAA, 1);
        chk("epp_count", 32'(count), 32'd1);
        chk("epp_popd",  popd, 32'hAA);
        chk("epp_unf",   32'(underflow), 32'd1);

        // overflow, clear, reset
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 32'(32'hB0 + i), 0);
        tick(0, 0, 1, 32'hCC, 0);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_popd",  popd, 32'hAA);
        tick(0, 1, 1, 32'hDD, 0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ovf",   32'(overflow), 32'd1);
        tick(1, 0, 0, 32'h0, 0);
        chk("rst2_ovf",  32'(overflow), 32'd0);
        chk("rst2_unf",  32'(underflow), 32'd0);

        // push/pop pairs across pointer wrap
        tick(0, 0, 1, $urandom, 0);
        for (int i = 0; i < 3 * DEPTH; i++) tick(0, 0, 1, $urandom, 1);

        // free-running random traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45));
        end

        tick(0, 0, 0, 32'h0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
